// File: rtl/sram_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sram_access_scheduler
// Brief   : Arbitrates N_REQ requesters onto one byte-wide SRAM access port
//           (fixed priority + starvation guard + round-robin) and routes
//           read data back to the issuing requester.
// Revision: 1.0  initial release
// ============================================================================
module sram_access_scheduler #(
  parameter int N_REQ        = 3,
  parameter int HI_PRI       = 0,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      req_we_i,
  input  logic [N_REQ*21-1:0]   req_addr_i,
  input  logic [N_REQ*8-1:0]    req_wdata_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [20:0]           mem_addr_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [7:0]            mem_writedata_o,
  input  logic [7:0]            mem_readdata_i,
  output logic [N_REQ-1:0]      rd_valid_o,
  output logic [7:0]            rd_data_o
);

  localparam int               PW      = $clog2(N_REQ);
  localparam logic [3:0]       LIMIT_Q = 4'(STARVE_LIMIT);
  localparam logic [N_REQ-1:0] HI_MASK = N_REQ'(1) << HI_PRI;

  logic [PW-1:0]    rr_q, rr_d;
  logic [3:0]       starve_q, starve_d;
  logic             others, hi_win;
  int               best_d, pick;
  logic [20:0]      sel_addr;
  logic [7:0]       sel_wdata;
  logic             sel_we;

  logic [20:0]      mem_addr_q;
  logic [7:0]       mem_wdata_q;
  logic             mem_read_q, mem_write_q;
  logic [N_REQ-1:0] rd_valid_q;
  logic [7:0]       rd_data_q;
  // Stage 0 is loaded together with the read strobe; a non-zero one-hot is the valid bit.
  logic [N_REQ-1:0] tag_q [0:LATENCY];

  always_comb begin
    gnt_o     = '0;
    rr_d      = rr_q;
    starve_d  = starve_q;
    best_d    = N_REQ;
    pick      = 0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    others    = |(req_i & ~HI_MASK);
    hi_win    = !rst_i && req_i[HI_PRI] && ((starve_q < LIMIT_Q) || !others);

    // Distance from the round-robin pointer decides the winner among the rest.
    for (int i = 0; i < N_REQ; i++) begin
      if (i != HI_PRI && req_i[i] && ((i + N_REQ - int'(rr_q)) % N_REQ) < best_d) begin
        best_d = (i + N_REQ - int'(rr_q)) % N_REQ;
        pick   = i;
      end
    end

    if (hi_win) begin
      gnt_o[HI_PRI] = 1'b1;
      if (!others)
        starve_d = 4'd0;
      else if (starve_q < LIMIT_Q)
        starve_d = starve_q + 4'd1;
    end else if (!rst_i && best_d < N_REQ) begin
      for (int i = 0; i < N_REQ; i++)
        if (i == pick) gnt_o[i] = 1'b1;
      rr_d     = PW'((pick + 1) % N_REQ);
      starve_d = 4'd0;
    end else begin
      starve_d = 4'd0;
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_o[i]) begin
        sel_addr  = req_addr_i[21*i +: 21];
        sel_wdata = req_wdata_i[8*i +: 8];
        sel_we    = req_we_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
    end else begin
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      mem_read_q  <= (|gnt_o) && !sel_we;
      mem_write_q <= (|gnt_o) && sel_we;
      if (|gnt_o) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      tag_q[0] <= ((|gnt_o) && !sel_we) ? gnt_o : '0;
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
      rd_valid_q <= tag_q[LATENCY];
      if (|tag_q[LATENCY]) rd_data_q <= mem_readdata_i;
    end
  end

  assign mem_addr_o      = mem_addr_q;
  assign mem_writedata_o = mem_wdata_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign rd_valid_o      = rd_valid_q;
  assign rd_data_o       = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_access_scheduler
// Brief   : Scoreboard bench: directed scenarios plus random traffic against a
//           behavioural arbitration / memory model.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_access_scheduler;

  localparam int N     = 3;
  localparam int HI    = 0;
  localparam int LAT   = 2;
  localparam int LIM   = 8;
  localparam int AW    = 21;
  localparam int BOUND = LIM * (N - 1) + N;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, we;
  logic [AW-1:0]     a [N];
  logic [7:0]        d [N];
  logic [N*AW-1:0]   addr_bus;
  logic [N*8-1:0]    wdata_bus;
  logic [N-1:0]      gnt, rd_valid;
  logic [AW-1:0]     mem_addr;
  logic              mem_read, mem_write;
  logic [7:0]        mem_wdata, rd_data;
  logic [7:0]        mem_rdata = 8'h00;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_bus[i*AW +: AW] = a[i];
      wdata_bus[i*8 +: 8]  = d[i];
    end
  end

  sram_access_scheduler #(.N_REQ(N), .HI_PRI(HI), .LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_we_i(we), .req_addr_i(addr_bus),
    .req_wdata_i(wdata_bus), .gnt_o(gnt), .mem_addr_o(mem_addr), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_writedata_o(mem_wdata), .mem_readdata_i(mem_rdata),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SRAM contents as seen by the bench: a fixed function of the address.
  function automatic logic [7:0] rdata_of(input logic [AW-1:0] ad);
    if (ad == 21'h00005) return 8'hA5;
    return ad[7:0] ^ ad[15:8] ^ {3'b101, ad[20:16]};
  endfunction

  // ---------------- reference model state ----------------
  typedef struct { int due; logic [N-1:0] oh; logic [7:0] data; } ret_t;
  typedef struct { int due; logic [7:0] data; } mrd_t;
  ret_t retq[$];
  mrd_t mrq[$];
  int   cyc = 0;
  int   m_rr = 0, m_starve = 0;
  int   waitc [N];
  logic exp_rd = 1'b0, exp_wr = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]    exp_wd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_pick(input logic [N-1:0] r);
    logic oth;
    oth = 1'b0;
    for (int i = 0; i < N; i++) if (i != HI && r[i]) oth = 1'b1;
    if (r[HI] && (m_starve < LIM || !oth)) return HI;
    for (int off = 0; off < N; off++) begin
      int k;
      k = (m_rr + off) % N;
      if (k != HI && r[k]) return k;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    ret_t r;
    mrd_t m;
    int   pick;
    logic oth;
    logic [N-1:0] exp_g;
    if (rst) begin
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_strobes", {30'b0, mem_read, mem_write}, 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      retq.delete();
      mrq.delete();
      m_rr = 0; m_starve = 0; exp_rd = 1'b0; exp_wr = 1'b0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
      mem_rdata = 8'($urandom);
    end else begin
      chk("mem_read", 32'(mem_read), 32'(exp_rd));
      chk("mem_write", 32'(mem_write), 32'(exp_wr));
      if (exp_rd || exp_wr) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_wr) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd));

      if (retq.size() > 0 && retq[0].due == cyc) begin
        r = retq.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'(r.oh));
        chk("rd_data", 32'(rd_data), 32'(r.data));
      end else if (rd_valid != '0) begin
        chk("rd_valid_spurious", 32'(rd_valid), 0);
      end

      // Memory responder: data for a read strobe lands LAT cycles later.
      if (mrq.size() > 0 && mrq[0].due == cyc) begin
        m = mrq.pop_front();
        mem_rdata = m.data;
      end else begin
        mem_rdata = 8'($urandom);
      end
      if (mem_read) begin
        m.due = cyc + LAT; m.data = rdata_of(mem_addr);
        mrq.push_back(m);
      end

      pick  = model_pick(req);
      exp_g = (pick >= 0) ? N'(1) << pick : '0;
      chk("gnt", 32'(gnt), 32'(exp_g));
      if (!$onehot0(gnt)) chk("gnt_onehot", 32'(gnt), 0);

      oth = 1'b0;
      for (int i = 0; i < N; i++) if (i != HI && req[i]) oth = 1'b1;
      if (pick == HI) m_starve = oth ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
      else begin
        m_starve = 0;
        if (pick >= 0) m_rr = (pick + 1) % N;
      end

      exp_rd = (pick >= 0) && !we[pick];
      exp_wr = (pick >= 0) && we[pick];
      if (pick >= 0) begin
        exp_addr = a[pick];
        exp_wd   = d[pick];
      end
      if (exp_rd) begin
        r.due = cyc + 2 + LAT; r.oh = exp_g; r.data = rdata_of(a[pick]);
        retq.push_back(r);
      end

      for (int i = 0; i < N; i++) begin
        if (i == HI) continue;
        if (pick == i) begin
          if (waitc[i] > BOUND) chk("starve_bound", 32'(waitc[i]), BOUND);
          waitc[i] = 0;
        end else if (req[i]) waitc[i]++;
        else waitc[i] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Issue the given requests and drop each one as it is granted.
  task automatic drain_grants(input int cycles);
    logic [N-1:0] g;
    for (int k = 0; k < cycles; k++) begin
      #1 g = gnt;
      tick();
      req = req & ~g;
    end
  endtask

  initial begin
    logic [N-1:0] g;
    rst = 1'b1; req = '0; we = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    repeat (2) tick();

    // Single read by requester 1.
    do_reset();
    a[1] = 21'h00005; we[1] = 1'b0; req = 3'b010;
    #1 chk("t1_gnt", 32'(gnt), 32'h2);
    tick(); req = '0;
    chk("t1_mem_read", 32'(mem_read), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h5);
    tick(); tick();
    chk("t1_rd_valid_early", 32'(rd_valid), 0);
    tick();
    chk("t1_rd_valid", 32'(rd_valid), 32'h2);
    chk("t1_rd_data", 32'(rd_data), 32'hA5);

    // HI_PRI versus requester 2: eight to one.
    do_reset();
    we = '0; req = 3'b101;
    for (int k = 0; k < 18; k++) begin
      #1 chk("t2_pattern", 32'(gnt), (k == 8 || k == 17) ? 32'h4 : 32'h1);
      tick();
      a[0] = AW'($urandom); a[2] = AW'($urandom);
    end
    req = '0;

    // Round-robin between 1 and 2.
    do_reset();
    req = 3'b110;
    for (int k = 0; k < 6; k++) begin
      #1 chk("t3_alternate", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h4);
      tick();
    end
    req = '0;

    // Back-to-back read / write / read.
    do_reset();
    a[0] = 21'h10; we[0] = 1'b0;
    a[1] = 21'h11; we[1] = 1'b1; d[1] = 8'h3C;
    a[2] = 21'h12; we[2] = 1'b0;
    req = 3'b111;
    drain_grants(3);
    tick();
    chk("t4_rv0", 32'(rd_valid), 32'h1);
    chk("t4_rd0", 32'(rd_data), 32'(rdata_of(21'h10)));
    tick();
    chk("t4_gap", 32'(rd_valid), 0);
    tick();
    chk("t4_rv2", 32'(rd_valid), 32'h4);
    chk("t4_rd2", 32'(rd_data), 32'(rdata_of(21'h12)));
    we = '0;

    // Reset while two reads are in flight.
    do_reset();
    a[1] = 21'h20; a[2] = 21'h21; req = 3'b110;
    drain_grants(2);
    #1 rst = 1'b1;
    #1;
    chk("t5_read_async", 32'(mem_read), 0);
    chk("t5_addr_async", 32'(mem_addr), 0);
    chk("t5_rv_async", 32'(rd_valid), 0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("t5_no_stale_rv", 32'(rd_valid), 0);
      tick();
    end
    req = 3'b110;
    #1 chk("t5_first_gnt", 32'(gnt), 32'h2);
    drain_grants(2);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      #1 g = gnt;
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i] || g[i]) begin
          if ($urandom_range(99) < ((i == HI) ? 60 : 35)) begin
            req[i] = 1'b1;
            we[i]  = 1'($urandom_range(1));
            a[i]   = AW'($urandom);
            d[i]   = 8'($urandom);
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
    req = '0;
    repeat (LAT + 4) tick();
    chk("drain_empty", 32'(retq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
